// File: rtl/mem_r1_w1_if.sv
// Signal bundle for the HIR memory port: port 0 read request/response, port 1 write, error flag.
// The master modport is the kernel side and the slave modport is the memory side.
interface mem_r1_w1_if #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int ADDR_WIDTH    = 10
);
    logic                     t;
    logic                     p0_rd_en;
    logic [ADDR_WIDTH-1:0]    p0_rd_addr;
    logic [ELEMENT_WIDTH-1:0] p0_rd_data;
    logic                     p0_rd_valid;
    logic                     p1_wr_en;
    logic [ADDR_WIDTH-1:0]    p1_wr_addr;
    logic [ELEMENT_WIDTH-1:0] p1_wr_data;
    logic                     err;

    modport master (
        output t, p0_rd_en, p0_rd_addr, p1_wr_en, p1_wr_addr, p1_wr_data,
        input  p0_rd_data, p0_rd_valid, err
    );

    modport slave (
        input  t, p0_rd_en, p0_rd_addr, p1_wr_en, p1_wr_addr, p1_wr_data,
        output p0_rd_data, p0_rd_valid, err
    );
endinterface

// File: rtl/mem_r1_w1.sv
// Simple dual-port RAM answering HIR read requests after a fixed RD_LATENCY (1..8) cycles.
// Define HIR_MEM_RD_FWD_EN for write-first same-address behaviour; otherwise reads are read-first.
module mem_r1_w1 #(
    parameter int ELEMENT_WIDTH = 32,
    parameter int DEPTH         = 1024,
    parameter int RD_LATENCY    = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_r1_w1_if.slave    bus
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ELEMENT_WIDTH-1:0] mem [DEPTH];
    logic [ELEMENT_WIDTH-1:0] rd_word;
    logic [ELEMENT_WIDTH-1:0] data_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]    valid_q;
    logic                     active;
    logic                     rd_ok;
    logic                     wr_ok;
    logic                     rd_req;
    logic                     wr_req;
    logic                     err_q;
    logic                     unused_t;

    // The start-time pulse exists only so every HIR memory has the same port list.
    assign unused_t = bus.t;

    assign rd_ok  = {1'b0, bus.p0_rd_addr} < DEPTH_W;
    assign wr_ok  = {1'b0, bus.p1_wr_addr} < DEPTH_W;
    assign rd_req = active & bus.p0_rd_en;
    assign wr_req = active & bus.p1_wr_en;

    // Reset release takes effect at the next clock edge; requests are accepted from then on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active <= 1'b0;
        else     active <= 1'b1;
    end

    // NOTE: the array has no reset so it maps onto block RAM; only control state is cleared.
    always_ff @(posedge clk) begin
        if (wr_req && wr_ok) mem[bus.p1_wr_addr] <= bus.p1_wr_data;
    end

    // NOTE: every variable gets a default first, so this block can never infer a latch.
    always_comb begin
        rd_word = '0;
        if (rd_ok) rd_word = mem[bus.p0_rd_addr];
`ifdef HIR_MEM_RD_FWD_EN
        if (wr_req && wr_ok && (bus.p1_wr_addr == bus.p0_rd_addr)) rd_word = bus.p1_wr_data;
`endif
    end

    // Stage 0 is the registered array read; later stages shift, each holding its last word.
    // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= rd_req;
            if (rd_req) data_q[0] <= rd_word;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     err_q <= 1'b0;
        else if ((rd_req && !rd_ok) || (wr_req && !wr_ok)) err_q <= 1'b1;
    end

    assign bus.p0_rd_data  = data_q[RD_LATENCY-1];
    assign bus.p0_rd_valid = valid_q[RD_LATENCY-1];
    assign bus.err         = err_q;
endmodule
